instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the immediate sign-extension path. Accepts decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit RV32 instruction word.
- Uses the same immsrc encoding as the datapath extender. It range-checks the immediate and stamps each emitted word with an instruction-memory byte address.
- Sits between a program loader or test sequencer and instruction-memory write logic.
- 2-stage valid/ready pipeline with full throughput and backpressure.

Parameters:
- ADDR_WIDTH, 32, width of the output byte address and of the load value.
- ERR_CNT_WIDTH, 8, width of the saturating dropped-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- immsrc  in  2  00 I-type, 01 S-type, 10 B-type, 11 R-type (no immediate).
- imm  in  32  immediate value, already sign-extended.
- opcode  in  7  instr[6:0].
- rd  in  5  instr[11:7] for I/R; ignored for S/B.
- funct3  in  3  instr[14:12].
- rs1  in  5  instr[19:15].
- rs2  in  5  instr[24:20] for S/B/R; ignored for I.
- funct7  in  7  instr[31:25] for R; ignored otherwise.
- addr_load  in  1  load the next-address counter.
- addr_load_val  in  ADDR_WIDTH  value loaded by addr_load.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts this cycle.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_WIDTH  byte address of out_instr.
- err_sticky  out  1  set when any word was dropped; cleared only by reset.
- err_count  out  ERR_CNT_WIDTH  dropped-word count, saturating at all-ones.

Behaviour:
- Reset (rst_n low at a clock edge):
  - s1_valid = 0, s2_valid = 0, so out_valid = 0.
  - out_instr = 0, out_addr = 0, next_addr = 0.
  - err_sticky = 0, err_count = 0.
  - Reset mid-stream discards all in-flight words. in_ready is 1 the first cycle after reset.
- Handshake:
  - A transfer happens when valid and ready are both high at a clock edge.
  - The producer holds its fields stable while valid is high and ready is low.
  - out_instr and out_addr are held stable while out_valid && !out_ready.
- Ready chain (combinational, no extra bubble):
  - s2_free = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
- Stage 1:
  - Registers the fields and computes imm_ok:
    - I/S: imm[31:11] all equal.
    - B: imm[31:12] all equal and imm[0] = 0.
    - R: imm_ok is always 1.
- Stage 1 -> stage 2 move (when s1_valid && s2_free):
  - If imm_ok = 0: the word is dropped, s2 is not loaded, err_sticky is set to 1, and err_count increments (saturating).
  - If imm_ok = 1: out_instr is loaded with the packed word and out_addr with the address (below).
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
- Latency: the accepted word appears on out_valid 2 cycles after acceptance when not stalled. Throughput is 1 word per cycle.
- Address:
  - A stage-2 load stamps out_addr = next_addr, then next_addr += 4 (wraps modulo 2^ADDR_WIDTH).
  - addr_load alone: next_addr <= addr_load_val.
  - addr_load in the same cycle as a stage-2 load: the word gets addr_load_val and next_addr <= addr_load_val + 4.
  - Dropped words do not advance next_addr.
- Round-trip invariant: for every emitted word, sign-extending out_instr with the same immsrc returns imm (I/S/B).

Decomposition:
- Shared package instr_pkg:
  - immsrc localparams IMM_I, IMM_S, IMM_B, IMM_R.
  - Field-position constants for the instruction layout.
  - Packed struct for the input field bundle.
- One combinational sub-module, imm_pack: inputs immsrc, imm and the register fields; outputs instr[31:0] and imm_ok.
- instr_encoder holds the pipeline registers, the address counter and the error counters.

Test Plan:
- I-type: immsrc=00, imm=0xFFFFF800 (-2048), rs1=2, funct3=0, rd=5, opcode=0x13, out_ready=1 -> 2 cycles later out_instr=0x80010293, out_addr=0.
- B-type: immsrc=10, imm=0xFFFFFFFC (-4), rs1=1, rs2=2, funct3=1, opcode=0x63 -> out_instr=0xFE209EE3. Second back-to-back word gets out_addr=4.
- Errors:
  - immsrc=00, imm=0x800 -> dropped; err_sticky=1, err_count=1, next_addr unchanged.
  - B-type with imm=3 -> dropped; err_count=2.
- Backpressure: stream 5 S-type words with out_ready toggling 1,0,0,1 -> no loss or duplication, words in order, out_instr stable while stalled, addresses 0,4,8,12,16.
- Address:
  - addr_load=1, addr_load_val=0x1000 coincident with a stage-2 load -> that word out_addr=0x1000, next 0x1004.
  - Load 0xFFFFFFFC -> following addresses 0xFFFFFFFC, 0x0.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages full -> out_valid=0, err_count=0, first post-reset word gets out_addr=0.
- Random round-trip over 1000 words: feed out_instr and immsrc into the existing sign-extend model and compare against the input imm.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the RV32 instruction encoder: immsrc codes,
// instruction field positions and the input field bundle.
package instr_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_R = 2'b11;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic [1:0]  immsrc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
    } fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: builds the RV32 word for the given immsrc and
// reports whether the immediate fits the format.
// Ports: i_immsrc, i_imm, register fields in; o_instr, o_imm_ok out.
module imm_pack
    import instr_pkg::*;
(
    input  logic [1:0]  i_immsrc,
    input  logic [31:0] i_imm,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    output logic [31:0] o_instr,
    output logic        o_imm_ok
);

    logic w_sx11;
    logic w_sx12;

    // Immediate fits when all bits above the sign bit copy the sign.
    assign w_sx11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_sx12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);

    always_comb begin
        o_instr  = '0;
        o_imm_ok = 1'b1;
        o_instr[OPC_LSB +: 7] = i_opcode;
        o_instr[F3_LSB  +: 3] = i_funct3;
        o_instr[RS1_LSB +: 5] = i_rs1;
        unique case (i_immsrc)
            IMM_I: begin
                o_instr[RD_LSB +: 5] = i_rd;
                o_instr[31:20]       = i_imm[11:0];
                o_imm_ok             = w_sx11;
            end
            IMM_S: begin
                o_instr[RS2_LSB +: 5] = i_rs2;
                o_instr[31:25]        = i_imm[11:5];
                o_instr[11:7]         = i_imm[4:0];
                o_imm_ok              = w_sx11;
            end
            IMM_B: begin
                o_instr[RS2_LSB +: 5] = i_rs2;
                o_instr[31]           = i_imm[12];
                o_instr[30:25]        = i_imm[10:5];
                o_instr[11:8]         = i_imm[4:1];
                o_instr[7]            = i_imm[11];
                o_imm_ok              = w_sx12 & ~i_imm[0];
            end
            IMM_R: begin
                o_instr[RD_LSB  +: 5] = i_rd;
                o_instr[RS2_LSB +: 5] = i_rs2;
                o_instr[F7_LSB  +: 7] = i_funct7;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: registers fields, packs and range-checks
// them, stamps an address and counts dropped words.
// Ports: in_* handshake + fields, addr_load*, out_* handshake, err_*.
module instr_encoder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               immsrc,
    input  logic [31:0]              imm,
    input  logic [6:0]               opcode,
    input  logic [4:0]               rd,
    input  logic [2:0]               funct3,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [6:0]               funct7,
    input  logic                     addr_load,
    input  logic [ADDR_WIDTH-1:0]    addr_load_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    import instr_pkg::*;

    fields_t                  r_s1;
    logic                     r_s1_valid;
    logic                     r_s2_valid;
    logic [31:0]              r_out_instr;
    logic [ADDR_WIDTH-1:0]    r_out_addr;
    logic [ADDR_WIDTH-1:0]    r_next_addr;
    logic                     r_err_sticky;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    fields_t                  w_in;
    logic                     w_s2_free;
    logic                     w_in_ready;
    logic                     w_move;
    logic                     w_load2;
    logic                     w_drop;
    logic [31:0]              w_s1_instr;
    logic                     w_s1_ok;
    logic [ADDR_WIDTH-1:0]    w_base;

    assign w_in = '{
        immsrc: immsrc, imm: imm, opcode: opcode, rd: rd,
        funct3: funct3, rs1: rs1, rs2: rs2, funct7: funct7
    };

    imm_pack u_pack (
        .i_immsrc (r_s1.immsrc),
        .i_imm    (r_s1.imm),
        .i_opcode (r_s1.opcode),
        .i_rd     (r_s1.rd),
        .i_funct3 (r_s1.funct3),
        .i_rs1    (r_s1.rs1),
        .i_rs2    (r_s1.rs2),
        .i_funct7 (r_s1.funct7),
        .o_instr  (w_s1_instr),
        .o_imm_ok (w_s1_ok)
    );

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_move     = r_s1_valid && w_s2_free;
    assign w_load2    = w_move && w_s1_ok;
    assign w_drop     = w_move && !w_s1_ok;
    // A coincident load takes priority over the running counter.
    assign w_base     = addr_load ? addr_load_val : r_next_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1         <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_out_instr  <= '0;
            r_out_addr   <= '0;
            r_next_addr  <= '0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (in_valid && w_in_ready) begin
                r_s1_valid <= 1'b1;
                r_s1       <= w_in;
            end else if (w_s2_free) begin
                r_s1_valid <= 1'b0;
            end

            if (w_load2) begin
                r_s2_valid  <= 1'b1;
                r_out_instr <= w_s1_instr;
                r_out_addr  <= w_base;
            end else if (w_s2_free) begin
                r_s2_valid <= 1'b0;
            end

            if (w_load2) begin
                r_next_addr <= w_base + ADDR_WIDTH'(4);
            end else if (addr_load) begin
                r_next_addr <= addr_load_val;
            end

            if (w_drop) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_s2_valid;
    assign out_instr  = r_out_instr;
    assign out_addr   = r_out_addr;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing, latency, drops, backpressure,
// address loads, reset flush and a random sign-extend round trip.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        addr_load;
    logic [31:0] addr_load_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_sticky;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_i[$];
    logic [31:0] got_a[$];
    logic [1:0]  q_src[$];
    logic [31:0] q_imm[$];
    logic [31:0] q_fld[$];

    logic        bp_mode = 1'b0;
    int          ph = 0;
    logic [3:0]  pat = 4'b1001;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_addr = '0;

    instr_encoder #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .imm(imm), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: records transfers and checks holds during stalls.
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            check("stall_hold", {out_valid, out_addr, out_instr},
                  {1'b1, prev_addr, prev_instr});
        end
        stall_prev = rst_n && out_valid && !out_ready;
        prev_instr = out_instr;
        prev_addr  = out_addr;
        if (rst_n && out_valid && out_ready) begin
            got_i.push_back(out_instr);
            got_a.push_back(out_addr);
        end
    end

    // Backpressure pattern driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end
        end
    end

    function automatic logic [31:0] sx_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] sx_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] sx_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    task automatic send(input logic [1:0] s, input logic [31:0] im,
                        input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [6:0] f7);
        bit ok;
        immsrc = s; imm = im; opcode = op; rd = d;
        funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] ei,
                               input logic [31:0] ea);
        logic [63:0] obs;
        obs = 'x;
        if (got_i.size() != 0) begin
            obs = {got_a.pop_front(), got_i.pop_front()};
        end
        check(tag, obs, {ea, ei});
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  s;
        logic [31:0] im;
        logic [31:0] fw;
        logic [31:0] w;
        logic [31:0] a;
        logic [127:0] obs;
        logic [127:0] exp;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        immsrc = '0; imm = '0; opcode = '0; rd = '0;
        funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0;
        addr_load = 1'b0; addr_load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {in_ready, out_valid, out_instr, out_addr, err_sticky, err_count},
              {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0});
        rst_n = 1'b1;

        // I then B back-to-back, latency and packing.
        send(2'b00, 32'hFFFFF800, 7'h13, 5'd5, 3'd0, 5'd2, 5'd0, 7'd0);
        check("lat_s1_only", out_valid, 1'b0);
        send(2'b10, 32'hFFFFFFFC, 7'h63, 5'd0, 3'd1, 5'd1, 5'd2, 7'd0);
        check("lat_s2", {out_valid, out_instr}, {1'b1, 32'h80010293});
        drain(6);
        check("cnt_ib", got_i.size(), 2);
        expect_word("i_type", 32'h80010293, 32'h0);
        expect_word("b_type", 32'hFE209EE3, 32'h4);

        // Range errors drop words without advancing the address.
        send(2'b00, 32'h00000800, 7'h13, 5'd5, 3'd0, 5'd2, 5'd0, 7'd0);
        drain(4);
        check("err1", {err_sticky, err_count}, {1'b1, 8'd1});
        send(2'b10, 32'h00000003, 7'h63, 5'd0, 3'd1, 5'd1, 5'd2, 7'd0);
        drain(4);
        check("err2", {err_sticky, err_count}, {1'b1, 8'd2});
        check("err_no_out", got_i.size(), 0);
        send(2'b11, 32'h0, 7'h33, 5'd6, 3'd0, 5'd4, 5'd3, 7'h20);
        drain(4);
        expect_word("r_after_err", 32'h40320333, 32'h8);

        // Fill both stages, then reset mid-stream.
        out_ready = 1'b0;
        send(2'b11, 32'h0, 7'h33, 5'd6, 3'd0, 5'd4, 5'd3, 7'h20);
        send(2'b11, 32'h0, 7'h33, 5'd6, 3'd0, 5'd4, 5'd3, 7'h20);
        check("full_pipe", {in_ready, out_valid}, {1'b0, 1'b1});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_reset",
              {in_ready, out_valid, err_sticky, err_count},
              {1'b1, 1'b0, 1'b0, 8'd0});
        check("mid_reset_no_out", got_i.size(), 0);

        // Backpressure stream of S-type words.
        bp_mode = 1'b1;
        send(2'b01, 32'h00000000, 7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'd0);
        send(2'b01, 32'h00000004, 7'h23, 5'd0, 3'd2, 5'd2, 5'd2, 7'd0);
        send(2'b01, 32'hFFFFFFF8, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0);
        send(2'b01, 32'h000007FF, 7'h23, 5'd0, 3'd2, 5'd2, 5'd4, 7'd0);
        send(2'b01, 32'hFFFFF800, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0);
        drain(16);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        drain(2);
        check("cnt_bp", got_i.size(), 5);
        expect_word("bp0", 32'h00112023, 32'd0);
        expect_word("bp1", 32'h00212223, 32'd4);
        expect_word("bp2", 32'hFE312C23, 32'd8);
        expect_word("bp3", 32'h7E412FA3, 32'd12);
        expect_word("bp4", 32'h80512023, 32'd16);

        // Address load coincident with a stage-2 load.
        send(2'b11, 32'h0, 7'h33, 5'd6, 3'd0, 5'd4, 5'd3, 7'h20);
        addr_load = 1'b1;
        addr_load_val = 32'h00001000;
        @(posedge clk);
        #1;
        addr_load = 1'b0;
        send(2'b11, 32'h0, 7'h33, 5'd6, 3'd0, 5'd4, 5'd3, 7'h20);
        drain(4);
        expect_word("ld_coinc", 32'h40320333, 32'h00001000);
        expect_word("ld_next", 32'h40320333, 32'h00001004);

        // Address load alone, then wrap.
        addr_load = 1'b1;
        addr_load_val = 32'hFFFFFFFC;
        @(posedge clk);
        #1;
        addr_load = 1'b0;
        send(2'b00, 32'hFFFFF800, 7'h13, 5'd5, 3'd0, 5'd2, 5'd0, 7'd0);
        send(2'b10, 32'hFFFFFFFC, 7'h63, 5'd0, 3'd1, 5'd1, 5'd2, 7'd0);
        drain(4);
        expect_word("wrap0", 32'h80010293, 32'hFFFFFFFC);
        expect_word("wrap1", 32'hFE209EE3, 32'h00000000);

        // Random round trip through an independent sign-extender.
        bp_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s = 2'($urandom_range(0, 3));
            v = $urandom;
            if (s == 2'b10) im = {{19{v[12]}}, v[12:1], 1'b0};
            else if (s == 2'b11) im = v;
            else im = {{20{v[11]}}, v[11:0]};
            fw = $urandom;
            q_src.push_back(s);
            q_imm.push_back(im);
            q_fld.push_back(fw);
            send(s, im, fw[6:0], fw[11:7], fw[14:12], fw[19:15],
                 fw[24:20], fw[31:25]);
        end
        drain(20);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        drain(2);
        check("cnt_rand", got_i.size(), 1000);
        for (int i = 0; i < 1000 && got_i.size() != 0; i++) begin
            w  = got_i.pop_front();
            a  = got_a.pop_front();
            s  = q_src.pop_front();
            im = q_imm.pop_front();
            fw = q_fld.pop_front();
            case (s)
                2'b00: begin
                    obs = {a, sx_i(w), w[19:0]};
                    exp = {32'd4 + 32'(i) * 32'd4, im, fw[19:0]};
                end
                2'b01: begin
                    obs = {a, sx_s(w), w[24:12], w[6:0]};
                    exp = {32'd4 + 32'(i) * 32'd4, im, fw[24:12], fw[6:0]};
                end
                2'b10: begin
                    obs = {a, sx_b(w), w[24:12], w[6:0]};
                    exp = {32'd4 + 32'(i) * 32'd4, im, fw[24:12], fw[6:0]};
                end
                default: begin
                    obs = {a, w};
                    exp = {32'd4 + 32'(i) * 32'd4, fw};
                end
            endcase
            check("roundtrip", obs, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
